// File: rtl/lock_pkg.sv
// Shared definitions for the clock/lock health checkers.
// Holds the default system clock frequency and the frequency checker state encoding.
// Imported by frequency_checker.
package lock_pkg;

  localparam int DEFAULT_CLK_FREQUENCY = 50000000;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } freqchk_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by an edge-detect register.
// rise/fall are combinational from the synchronized level and its delayed copy, so they
// appear two clk edges after the first sampling edge.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s_d;

  // Metastability chain plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= d;
      s2  <= s1;
      s_d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s_d;
  assign fall  = ~s2 & s_d;

endmodule

// File: rtl/frequency_checker.sv
// Measures period and high time of a slow asynchronous signal in clk cycles, checks the
// period against the expected value and declares loss of signal after TIMEOUT_CYCLES
// without a rising edge. Results are registered, three clk edges after the input is sampled.
module frequency_checker
  import lock_pkg::*;
#(
  parameter int CLK_FREQUENCY          = DEFAULT_CLK_FREQUENCY,
  parameter int REQUIRED_CLK_FREQUENCY = 1,
  parameter int TOLERANCE              = 0,
  parameter int TIMEOUT_CYCLES         = 2 * (CLK_FREQUENCY / REQUIRED_CLK_FREQUENCY),
  parameter int CNT_WIDTH              = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 freq_ok,
  output logic                 no_signal,
  output logic                 timeout
);

  localparam int EXPECTED_PERIOD = CLK_FREQUENCY / REQUIRED_CLK_FREQUENCY;

  localparam logic [CNT_WIDTH-1:0] EXP_W = CNT_WIDTH'(EXPECTED_PERIOD);
  localparam logic [CNT_WIDTH-1:0] TOL_W = CNT_WIDTH'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] TO_W  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE_W = CNT_WIDTH'(1);

  freqchk_state_t       state_q;
  freqchk_state_t       state_d;
  logic                 rise;
  logic                 fall;
  logic                 unused_level;
  logic                 do_meas;
  logic                 do_timeout;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hi_cnt;
  logic [CNT_WIDTH-1:0] diff;
  logic                 in_tol;

  edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .level (unused_level),
    .rise  (rise),
    .fall  (fall)
  );

  // Unsigned distance from the expected period, taken in whichever direction avoids wrap.
  assign diff   = (cnt >= EXP_W) ? (cnt - EXP_W) : (EXP_W - cnt);
  assign in_tol = (diff <= TOL_W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and measurement/timeout strobes; a rise on the timeout cycle wins.
  always_comb begin
    state_d    = state_q;
    do_meas    = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEAS;
      end
      MEAS: begin
        if (rise) begin
          do_meas = 1'b1;
        end else if (cnt == TO_W) begin
          do_timeout = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cycle counter since the last rise and high-time capture; parked at 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      hi_cnt <= '0;
    end else begin
      if (rise)                 cnt <= ONE_W;
      else if (do_timeout)      cnt <= '0;
      else if (state_q == MEAS) cnt <= cnt + ONE_W;
      if (state_q == MEAS && fall) hi_cnt <= cnt;
    end
  end

  // Registered results and status; meas_valid and timeout are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      no_signal  <= 1'b1;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= do_meas;
      timeout    <= do_timeout;
      if (do_meas) begin
        period    <= cnt;
        high_time <= hi_cnt;
        freq_ok   <= in_tol;
        no_signal <= 1'b0;
      end else if (do_timeout) begin
        freq_ok   <= 1'b0;
        no_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frequency_checker.sv
// Randomized and directed bench for frequency_checker with a time-stamp based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge every cycle.
// The model works on sample indices of rising/falling edges and delays its result by the pipeline.
module tb_frequency_checker;

  localparam int CW       = 8;
  localparam int EXP_PER  = 10;
  localparam int TOL      = 1;
  localparam int TMO      = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          freq_ok;
  logic          no_signal;
  logic          timeout;

  frequency_checker #(
    .CLK_FREQUENCY          (20),
    .REQUIRED_CLK_FREQUENCY (2),
    .TOLERANCE              (TOL),
    .TIMEOUT_CYCLES         (TMO),
    .CNT_WIDTH              (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .freq_ok    (freq_ok),
    .no_signal  (no_signal),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    bit vld;
    bit ok;
    bit nos;
    bit tmo;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_meas   = 0;
  int   n_tmo    = 0;

  // Reference model state: sample index, edge time stamps, armed flag.
  int   smp;
  int   ref_rise;
  int   last_fall;
  bit   armed;
  bit   prev_v;
  exp_t cur;
  exp_t pipe [3];

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
    end
  endtask

  function automatic exp_t reset_vals();
    exp_t e;
    e.per = 0; e.hi = 0; e.vld = 0; e.ok = 0; e.nos = 1; e.tmo = 0;
    return e;
  endfunction

  task automatic model_reset();
    smp = 0; ref_rise = 0; last_fall = 0; armed = 0; prev_v = 0;
    cur = reset_vals();
    for (int i = 0; i < 3; i++) pipe[i] = reset_vals();
  endtask

  task automatic model_sample(input bit v);
    bit r, f;
    int p;
    r = v & ~prev_v;
    f = ~v & prev_v;
    prev_v = v;
    cur.vld = 0;
    cur.tmo = 0;
    if (r) begin
      if (armed) begin
        p = smp - ref_rise;
        cur.per = p;
        cur.hi  = last_fall - ref_rise;
        cur.ok  = ((p > EXP_PER) ? p - EXP_PER : EXP_PER - p) <= TOL;
        cur.vld = 1;
        cur.nos = 0;
      end
      armed = 1;
      ref_rise = smp;
    end else if (armed && (smp - ref_rise) == TMO) begin
      cur.tmo = 1;
      cur.nos = 1;
      cur.ok  = 0;
      armed   = 0;
    end
    if (f && armed) last_fall = smp;
    smp++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = cur;
  endtask

  task automatic compare_outputs(input exp_t e);
    check_eq("period",     int'(period),     e.per);
    check_eq("high_time",  int'(high_time),  e.hi);
    check_eq("meas_valid", int'(meas_valid), int'(e.vld));
    check_eq("freq_ok",    int'(freq_ok),    int'(e.ok));
    check_eq("no_signal",  int'(no_signal),  int'(e.nos));
    check_eq("timeout",    int'(timeout),    int'(e.tmo));
    if (e.vld) n_meas++;
    if (e.tmo) n_tmo++;
  endtask

  // One clk cycle: check what the DUT shows now, drive the next input, model its sample.
  task automatic step(input bit v);
    @(negedge clk);
    compare_outputs(pipe[2]);
    sig_in = v;
    @(posedge clk);
    model_sample(v);
  endtask

  task automatic drive(input bit v, input int cycles);
    for (int i = 0; i < cycles; i++) step(v);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  // Asynchronous reset between clock edges; outputs must return to reset values at once.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    model_reset();
    compare_outputs(reset_vals());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi, lo;
    model_reset();
    rst_n = 1'b0;
    #13;
    compare_outputs(reset_vals());
    @(negedge clk);
    rst_n = 1'b1;

    // Idle low input: no pulses, no_signal stays set.
    drive(1'b0, 30);

    // Nominal 5/5 square wave.
    wave(5, 5, 4);

    // Period 11 (in tolerance), then 12 (out of tolerance), then nominal again.
    wave(6, 5, 1);
    wave(6, 6, 1);
    wave(5, 5, 2);

    // Rise then stuck low -> timeout; then re-arm and measure.
    drive(1'b1, 5);
    drive(1'b0, 40);
    wave(5, 5, 3);

    // Rise exactly at the timeout count gives a measurement of 20.
    wave(10, 10, 2);
    wave(5, 5, 1);

    // Stuck high -> timeout.
    drive(1'b1, 45);
    drive(1'b0, 5);
    wave(5, 5, 3);

    // Reset in the middle of a period, then resume.
    drive(1'b1, 3);
    apply_reset();
    wave(5, 5, 4);

    // Randomized periods, mostly near nominal, sometimes long enough to time out.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        hi = $urandom_range(1, 25);
        lo = $urandom_range(1, 25);
      end else begin
        hi = $urandom_range(3, 7);
        lo = $urandom_range(3, 7);
      end
      wave(hi, lo, 1);
      if ($urandom_range(0, 60) == 0) apply_reset();
    end
    drive(1'b0, 30);

    if (n_meas == 0) begin
      n_fail++;
      $display("FAIL activity: no measurements expected by model (got %0d, required >0)", n_meas);
    end
    if (n_tmo == 0) begin
      n_fail++;
      $display("FAIL activity: no timeouts expected by model (got %0d, required >0)", n_tmo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
